// File: rtl/pll_lock_seq_pkg.sv
// Shared state encoding and helpers for the PLL reset/lock sequencer.
// State encodings 5..7 are illegal and are recovered by the FSM.
package pll_lock_seq_pkg;

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_e;

    localparam int RELOCK_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        return (&v) ? v : v + {{(RELOCK_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pll_lock_seq_sync_ff.sv
// Generic N-flop synchronizer for single-bit asynchronous inputs, clears to 0.
// No logic may sit between the raw input and the first flop.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the raw input one stage per clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // synchronizer chain register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_seq.sv
// Reset/lock sequencer for the EHXPLLL: pulses PLL reset, qualifies LOCK over a
// stability window, releases the system reset and re-sequences on loss of lock.
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 25000,
    parameter int STABLE_CYCLES = 2500,
    parameter int MAX_RETRY     = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] relock_cnt
);

    localparam int MAX_COUNT = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    logic                lock_s;
    state_e              state_q,  state_d;
    logic [TW-1:0]       timer_q,  timer_d;
    logic [3:0]          retry_q,  retry_d;
    logic [3:0]          retry_inc_s;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_q, sys_rst_d;
    logic                ready_q,   ready_d;
    logic                fault_q,   fault_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    // next-state, counters and output decode (outputs follow next_state)
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        retry_d     = retry_q;
        relock_d    = relock_q;
        retry_inc_s = retry_q + 4'd1;
        case (state_q)
            S_PLLRST: begin
                if (timer_q == TW'(RST_CYCLES - 1)) state_d = S_WAIT;
                else                                 state_d = S_PLLRST;
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc_s;
                    if (retry_inc_s == 4'(MAX_RETRY)) state_d = S_FAULT;
                    else                               state_d = S_PLLRST;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end else begin
                    state_d = S_STABLE;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d  = S_PLLRST;
                    relock_d = sat_inc(relock_q);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_PLLRST;
        endcase

        if (state_d != state_q) timer_d = '0;
        else                    timer_d = timer_d;

        pll_rst_d = (state_d == S_PLLRST) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    // state, counters and registered outputs
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLLRST;
            timer_q   <= '0;
            retry_q   <= 4'd0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign state      = state_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: a phase/elapsed-time reference model predicts
// the outputs after every clkin edge; a separate monitor pops and compares them.
module tb_pll_lock_seq;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 10;
    localparam int MR = 2;
    localparam int SS = 2;

    localparam int P_PLLRST = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       pr;
        logic       sr;
        logic       rd;
        logic       ft;
        logic [7:0] rc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [2:0] state;
    logic [7:0] relock_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    obs_t exp_q[$];

    // reference model: phase, when it was entered, retries, relocks, sync delay line
    int m_phase, m_entry, m_cyc, m_retry, m_relock;
    bit m_pipe[SS];

    pll_lock_seq #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRY    (MR),
        .SYNC_STAGES  (SS)
    ) dut (
        .clkin      (clk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .state      (state),
        .relock_cnt (relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.st = 3'(m_phase);
        o.pr = (m_phase == P_PLLRST) || (m_phase == P_FAULT);
        o.sr = (m_phase != P_RUN);
        o.rd = (m_phase == P_RUN);
        o.ft = (m_phase == P_FAULT);
        o.rc = 8'(m_relock);
        return o;
    endfunction

    task automatic model_reset();
        m_phase  = P_PLLRST;
        m_entry  = m_cyc;
        m_retry  = 0;
        m_relock = 0;
        for (int i = 0; i < SS; i++) m_pipe[i] = 1'b0;
    endtask

    task automatic model_edge(input bit l);
        int  el;
        int  nxt;
        bit  ls;
        el  = m_cyc - m_entry;
        ls  = m_pipe[SS-1];
        for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = l;
        m_cyc++;
        nxt = m_phase;
        if (m_phase == P_PLLRST) begin
            if (el == RC - 1) nxt = P_WAIT;
        end else if (m_phase == P_WAIT) begin
            if (ls) nxt = P_STABLE;
            else if (el == LT - 1) begin
                m_retry++;
                nxt = (m_retry == MR) ? P_FAULT : P_PLLRST;
            end
        end else if (m_phase == P_STABLE) begin
            if (!ls) nxt = P_WAIT;
            else if (el == SC - 1) begin
                nxt = P_RUN;
                m_retry = 0;
            end
        end else if (m_phase == P_RUN) begin
            if (!ls) begin
                nxt = P_PLLRST;
                if (m_relock < 255) m_relock++;
            end
        end
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_entry = m_cyc;
        end
    endtask

    // apply inputs for the coming edge, predict the result, wait past the edge
    task automatic tick(input logic l, input logic r);
        locked = l;
        rst    = r;
        if (r) model_reset();
        else   model_edge(l);
        exp_q.push_back(model_out());
        @(posedge clk);
        #4;
    endtask

    task automatic run(input int n, input logic l);
        for (int i = 0; i < n; i++) tick(l, 1'b0);
    endtask

    task automatic reset_dut(input logic l);
        tick(l, 1'b1);
        tick(l, 1'b1);
    endtask

    task automatic wait_phase(input int ph, input logic l, input int budget, input string name);
        int n;
        n = 0;
        while (m_phase != ph && n < budget) begin
            tick(l, 1'b0);
            n++;
        end
        check(name, state, ph);
    endtask

    task automatic wait_el(input int ph, input int el, input logic l, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_phase == ph && (m_cyc - m_entry) == el) && n < budget) begin
            tick(l, 1'b0);
            n++;
        end
        check(name, m_cyc - m_entry, el);
    endtask

    // monitor: compare DUT outputs shortly after every edge against the scoreboard
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{state, pll_rst, sys_rst, ready, fault, relock_cnt};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL outputs @%0t: got st=%0d pr=%b sr=%b rd=%b ft=%b rc=%0d, expected st=%0d pr=%b sr=%b rd=%b ft=%b rc=%0d",
                              $time, a.st, a.pr, a.sr, a.rd, a.ft, a.rc, e.st, e.pr, e.sr, e.rd, e.ft, e.rc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic l;
        m_cyc = 0;
        model_reset();
        @(posedge clk);
        #4;

        // 1: normal lock
        reset_dut(1'b0);
        check("rst_state", state, P_PLLRST);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        cnt = 0;
        do begin tick(1'b0, 1'b0); cnt++; end while (pll_rst === 1'b1 && cnt < 50);
        check("t1_pll_rst_len", cnt, RC);
        run(2, 1'b0);
        cnt = 0;
        do begin tick(1'b1, 1'b0); cnt++; end while (sys_rst !== 1'b0 && cnt < 50);
        check("t1_lock_to_sys_rst", cnt, 13);
        run(5, 1'b1);
        check("t1_ready", ready, 1);
        check("t1_relock", relock_cnt, 0);

        // 2: one-cycle lock glitch seen at STABLE timer 6
        reset_dut(1'b1);
        wait_el(P_STABLE, 4, 1'b1, 100, "t2_reach_stable");
        tick(1'b0, 1'b0);
        run(2, 1'b1);
        check("t2_back_to_wait", state, P_WAIT);
        check("t2_sys_rst", sys_rst, 1);
        wait_phase(P_RUN, 1'b1, 100, "t2_run");

        // 3: lock never comes -> FAULT after MR timeouts
        reset_dut(1'b0);
        run(2 * (RC + LT) + 5, 1'b0);
        check("t3_state", state, P_FAULT);
        check("t3_fault", fault, 1);
        check("t3_pll_rst", pll_rst, 1);
        check("t3_sys_rst", sys_rst, 1);
        run(20, 1'b1);
        check("t3_sticky", state, P_FAULT);

        // 4: repeated loss of lock in RUN, relock counter saturates
        reset_dut(1'b1);
        wait_phase(P_RUN, 1'b1, 100, "t4_first_run");
        for (int i = 0; i < 300; i++) begin
            run($urandom_range(1, 4), 1'b1);
            tick(1'b0, 1'b0);
            run(2, 1'b1);
            check("t4_pll_rst_after_drop", pll_rst, 1);
            wait_phase(P_RUN, 1'b1, 60, "t4_relock");
        end
        check("t4_relock_sat", relock_cnt, 255);

        // 5: async reset mid-STABLE
        tick(1'b0, 1'b0);
        run(2, 1'b1);
        wait_el(P_STABLE, 5, 1'b1, 100, "t5_reach_stable");
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_state", state, P_PLLRST);
        check("t5_pll_rst", pll_rst, 1);
        check("t5_sys_rst", sys_rst, 1);
        check("t5_relock", relock_cnt, 0);
        tick(1'b1, 1'b1);
        wait_phase(P_RUN, 1'b1, 100, "t5_restart");

        // 6: lock arrives exactly on the timeout cycle
        reset_dut(1'b0);
        wait_el(P_WAIT, LT - 1 - SS, 1'b0, 100, "t6_reach_wait");
        run(3, 1'b1);
        check("t6_lock_priority", state, P_STABLE);
        wait_phase(P_RUN, 1'b1, 100, "t6_run");

        // 7: random soak with occasional resets
        l = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) l = ~l;
            tick(l, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        @(posedge clk);
        #6;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
